// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and decode/control bundles for the
// multi-cycle MIPS controller.
package mips_ctrl_pkg;

    // Primary opcodes understood by the controller
    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_BGTZ   = 6'd7;
    localparam logic [5:0] OP_ADDI   = 6'd8;
    localparam logic [5:0] OP_ADDIU  = 6'd9;
    localparam logic [5:0] OP_ANDI   = 6'd12;
    localparam logic [5:0] OP_ORI    = 6'd13;
    localparam logic [5:0] OP_MUL    = 6'd28;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    // ALU32Bit operation codes
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_NOR = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd9;
    localparam logic [3:0] ALU_SLL = 4'd10;
    localparam logic [3:0] ALU_GTZ = 4'd11;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_ADDR   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_BRANCH = 4'd6,
        ST_JUMP   = 4'd7,
        ST_MUL    = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_MUL     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_e;

    // Everything the FSM needs to know about one instruction
    typedef struct packed {
        instr_class_e cls;
        logic [3:0]   alu_ctrl;
        logic         alu_a_src;
        logic [1:0]   alu_b_src;
        logic         ext_sign;
        logic         reg_dst;
        logic         rt_illegal;
    } dec_t;

    // Datapath control bundle
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_a_src;
        logic [1:0] alu_b_src;
        logic [3:0] alu_ctrl;
        logic       ext_sign;
        logic       instr_done;
        logic       illegal;
        logic       error;
    } ctrl_t;

endpackage

// File: rtl/multicycle_mips_controller_decode.sv
// Combinational instruction decoder: opcode/funct/rt -> instruction class
// and the ALU settings used by the EXEC, BRANCH and MUL states.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic [4:0] i_rt,
    output dec_t       o_dec
);

    dec_t w_dec;

    // Classify the instruction; anything not recognised stays CLS_ILLEGAL
    always_comb begin
        w_dec     = '0;
        w_dec.cls = CLS_ILLEGAL;
        case (i_opcode)
            OP_RTYPE: begin
                w_dec.cls       = CLS_ALU;
                w_dec.reg_dst   = 1'b1;
                w_dec.alu_b_src = 2'd0;
                case (i_funct)
                    FN_ADD, FN_ADDU: w_dec.alu_ctrl = ALU_ADD;
                    FN_SUB:          w_dec.alu_ctrl = ALU_SUB;
                    FN_AND:          w_dec.alu_ctrl = ALU_AND;
                    FN_OR:           w_dec.alu_ctrl = ALU_OR;
                    FN_NOR:          w_dec.alu_ctrl = ALU_NOR;
                    FN_SLT:          w_dec.alu_ctrl = ALU_SLT;
                    FN_SLL: begin
                        // A = rt; B = zero-extended immediate whose bits [10:6] carry shamt
                        w_dec.alu_ctrl  = ALU_SLL;
                        w_dec.alu_a_src = 1'b1;
                        w_dec.alu_b_src = 2'd1;
                    end
                    default: begin
                        w_dec.cls     = CLS_ILLEGAL;
                        w_dec.reg_dst = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                w_dec.cls       = CLS_ALU;
                w_dec.alu_ctrl  = ALU_ADD;
                w_dec.alu_b_src = 2'd1;
                w_dec.ext_sign  = 1'b1;
            end
            OP_ADDIU: begin
                w_dec.cls       = CLS_ALU;
                w_dec.alu_ctrl  = ALU_ADD;
                w_dec.alu_b_src = 2'd1;
            end
            OP_ANDI: begin
                w_dec.cls       = CLS_ALU;
                w_dec.alu_ctrl  = ALU_AND;
                w_dec.alu_b_src = 2'd1;
            end
            OP_ORI: begin
                w_dec.cls       = CLS_ALU;
                w_dec.alu_ctrl  = ALU_OR;
                w_dec.alu_b_src = 2'd1;
            end
            OP_LW: begin
                w_dec.cls       = CLS_LOAD;
                w_dec.alu_ctrl  = ALU_ADD;
                w_dec.alu_b_src = 2'd1;
                w_dec.ext_sign  = 1'b1;
            end
            OP_SW: begin
                w_dec.cls       = CLS_STORE;
                w_dec.alu_ctrl  = ALU_ADD;
                w_dec.alu_b_src = 2'd1;
                w_dec.ext_sign  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_dec.cls      = CLS_BRANCH;
                w_dec.alu_ctrl = ALU_SUB;
            end
            OP_REGIMM: begin
                w_dec.cls        = CLS_BRANCH;
                w_dec.alu_ctrl   = ALU_SLT;
                w_dec.alu_b_src  = 2'd2;
                w_dec.rt_illegal = (i_rt != RT_BLTZ) && (i_rt != RT_BGEZ);
            end
            OP_BGTZ: begin
                w_dec.cls       = CLS_BRANCH;
                w_dec.alu_ctrl  = ALU_GTZ;
                w_dec.alu_b_src = 2'd2;
            end
            OP_J: begin
                w_dec.cls = CLS_JUMP;
            end
            OP_MUL: begin
                w_dec.cls      = CLS_MUL;
                w_dec.alu_ctrl = ALU_MUL;
                w_dec.reg_dst  = 1'b1;
            end
            default: begin
                w_dec.cls = CLS_ILLEGAL;
            end
        endcase
    end

    assign o_dec = w_dec;

endmodule

// File: rtl/multicycle_mips_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a
// single memory port with a MemReady handshake, a timeout watchdog and a
// fixed-length multiplier phase.
module multicycle_mips_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic        Zero,
    input  logic        ALUResult0,
    input  logic        MemReady,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  PCSource,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        ALUASrc,
    output logic [1:0]  ALUBSrc,
    output logic [3:0]  ALUControl,
    output logic        ExtendSign,
    output logic        InstrDone,
    output logic        Illegal,
    output logic        Error
);

    // Counters only ever reach LIMIT-1, so log2(LIMIT) bits suffice
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int MUL_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_e            r_state;
    state_e            w_next_state;
    logic [5:0]        r_opcode;
    logic [5:0]        r_funct;
    logic [4:0]        r_rt;
    logic [WAIT_W-1:0] r_wait;
    logic [MUL_W-1:0]  r_mul;
    logic              r_error;

    logic [5:0]        w_dec_opcode;
    logic [5:0]        w_dec_funct;
    logic [4:0]        w_dec_rt;
    dec_t              w_dec;
    logic              w_mem_wait;
    logic              w_timeout;
    logic              w_mul_last;
    logic              w_taken;
    ctrl_t             w_ctrl;
    ctrl_t             w_out;

    assign w_mem_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !MemReady;
    assign w_timeout  = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
    assign w_mul_last = (r_mul == MUL_W'(MUL_CYCLES - 1));

    // In DECODE the IR is decoded live; afterwards the latched fields are used
    always_comb begin
        if (r_state == ST_DECODE) begin
            w_dec_opcode = Instruction[31:26];
            w_dec_funct  = Instruction[5:0];
            w_dec_rt     = Instruction[20:16];
        end else begin
            w_dec_opcode = r_opcode;
            w_dec_funct  = r_funct;
            w_dec_rt     = r_rt;
        end
    end

    mips_ctrl_decode u_decode (
        .i_opcode (w_dec_opcode),
        .i_funct  (w_dec_funct),
        .i_rt     (w_dec_rt),
        .o_dec    (w_dec)
    );

    // Branch condition for the instruction latched at DECODE
    always_comb begin
        case (r_opcode)
            OP_BEQ:    w_taken = Zero;
            OP_BNE:    w_taken = !Zero;
            OP_BGTZ:   w_taken = ALUResult0;
            OP_REGIMM: w_taken = (r_rt == RT_BGEZ) ? !ALUResult0 : ALUResult0;
            default:   w_taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch instruction fields once, in DECODE
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_opcode <= 6'd0;
            r_funct  <= 6'd0;
            r_rt     <= 5'd0;
        end else if (r_state == ST_DECODE) begin
            r_opcode <= Instruction[31:26];
            r_funct  <= Instruction[5:0];
            r_rt     <= Instruction[20:16];
        end
    end

    // Memory wait counter and sticky timeout flag
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wait  <= '0;
            r_error <= 1'b0;
        end else begin
            if (w_mem_wait && !w_timeout) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_mem_wait && w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    // Multiplier phase counter, restarted on every entry to MUL
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_mul <= '0;
        end else if ((r_state == ST_MUL) && !w_mul_last) begin
            r_mul <= r_mul + MUL_W'(1);
        end else begin
            r_mul <= '0;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_read = 1'b1;
                if (MemReady) begin
                    w_ctrl.ir_write  = 1'b1;
                    w_ctrl.pc_write  = 1'b1;
                    w_ctrl.pc_source = 2'd0;
                    w_next_state     = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (Instruction == 32'd0) begin
                    w_ctrl.instr_done = 1'b1;
                    w_next_state      = ST_FETCH;
                end else begin
                    case (w_dec.cls)
                        CLS_ALU:              w_next_state = ST_EXEC;
                        CLS_LOAD, CLS_STORE:  w_next_state = ST_ADDR;
                        CLS_BRANCH:           w_next_state = ST_BRANCH;
                        CLS_JUMP:             w_next_state = ST_JUMP;
                        CLS_MUL:              w_next_state = ST_MUL;
                        default: begin
                            w_ctrl.illegal    = 1'b1;
                            w_ctrl.instr_done = 1'b1;
                            w_next_state      = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                w_ctrl.alu_ctrl  = w_dec.alu_ctrl;
                w_ctrl.alu_a_src = w_dec.alu_a_src;
                w_ctrl.alu_b_src = w_dec.alu_b_src;
                w_ctrl.ext_sign  = w_dec.ext_sign;
                w_next_state     = ST_WB;
            end
            ST_ADDR: begin
                w_ctrl.alu_ctrl  = ALU_ADD;
                w_ctrl.alu_b_src = 2'd1;
                w_ctrl.ext_sign  = 1'b1;
                w_next_state     = ST_MEM;
            end
            ST_MEM: begin
                w_ctrl.iord      = 1'b1;
                w_ctrl.mem_read  = (w_dec.cls == CLS_LOAD);
                w_ctrl.mem_write = (w_dec.cls != CLS_LOAD);
                if (MemReady) begin
                    if (w_dec.cls == CLS_LOAD) begin
                        w_next_state = ST_WB;
                    end else begin
                        w_ctrl.instr_done = 1'b1;
                        w_next_state      = ST_FETCH;
                    end
                end else if (w_timeout) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_MEM;
                end
            end
            ST_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = w_dec.reg_dst;
                w_ctrl.mem_to_reg = (w_dec.cls == CLS_LOAD);
                w_ctrl.instr_done = 1'b1;
                w_next_state      = ST_FETCH;
            end
            ST_BRANCH: begin
                w_ctrl.alu_ctrl   = w_dec.alu_ctrl;
                w_ctrl.alu_b_src  = w_dec.alu_b_src;
                w_ctrl.pc_source  = 2'd1;
                w_ctrl.instr_done = 1'b1;
                if (w_dec.rt_illegal) begin
                    w_ctrl.illegal = 1'b1;
                end else begin
                    w_ctrl.pc_write = w_taken;
                end
                w_next_state = ST_FETCH;
            end
            ST_JUMP: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = 2'd2;
                w_ctrl.instr_done = 1'b1;
                w_next_state      = ST_FETCH;
            end
            ST_MUL: begin
                w_ctrl.alu_ctrl = w_dec.alu_ctrl;
                if (w_mul_last) begin
                    w_next_state = ST_WB;
                end else begin
                    w_next_state = ST_MUL;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // Hold every output low while reset is asserted; Error comes from the sticky flag
    always_comb begin
        if (!Reset) begin
            w_out = '0;
        end else begin
            w_out       = w_ctrl;
            w_out.error = r_error;
        end
    end

    assign MemRead    = w_out.mem_read;
    assign MemWrite   = w_out.mem_write;
    assign IorD       = w_out.iord;
    assign IRWrite    = w_out.ir_write;
    assign PCWrite    = w_out.pc_write;
    assign PCSource   = w_out.pc_source;
    assign RegWrite   = w_out.reg_write;
    assign RegDst     = w_out.reg_dst;
    assign MemtoReg   = w_out.mem_to_reg;
    assign ALUASrc    = w_out.alu_a_src;
    assign ALUBSrc    = w_out.alu_b_src;
    assign ALUControl = w_out.alu_ctrl;
    assign ExtendSign = w_out.ext_sign;
    assign InstrDone  = w_out.instr_done;
    assign Illegal    = w_out.illegal;
    assign Error      = w_out.error;

endmodule

// File: tb/tb_multicycle_mips_controller.sv
// Self-checking bench: a per-instruction cycle model builds the expected
// control trace, which is then replayed against the controller.
module tb_multicycle_mips_controller;

    localparam int MUL_CYCLES  = 4;
    localparam int MEM_TIMEOUT = 15;

    localparam int K_NOP = 0, K_ALU = 1, K_LW = 2, K_SW = 3;
    localparam int K_BR  = 4, K_J   = 5, K_MUL = 6, K_ILL = 7;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_a_src;
        logic [1:0] alu_b_src;
        logic [3:0] alu_ctrl;
        logic       ext_sign;
        logic       instr_done;
        logic       illegal;
        logic       error;
    } exp_t;

    typedef struct {
        logic        rdy;
        logic        zero;
        logic        res0;
        logic [31:0] instr;
        exp_t        exp;
    } cyc_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Instruction = 32'd0;
    logic        Zero = 1'b0;
    logic        ALUResult0 = 1'b0;
    logic        MemReady = 1'b0;
    logic        MemRead, MemWrite, IorD, IRWrite, PCWrite;
    logic [1:0]  PCSource;
    logic        RegWrite, RegDst, MemtoReg, ALUASrc;
    logic [1:0]  ALUBSrc;
    logic [3:0]  ALUControl;
    logic        ExtendSign, InstrDone, Illegal, Error;

    exp_t obs;
    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    multicycle_mips_controller #(
        .MUL_CYCLES  (MUL_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Instruction (Instruction),
        .Zero        (Zero),
        .ALUResult0  (ALUResult0),
        .MemReady    (MemReady),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCSource    (PCSource),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUASrc     (ALUASrc),
        .ALUBSrc     (ALUBSrc),
        .ALUControl  (ALUControl),
        .ExtendSign  (ExtendSign),
        .InstrDone   (InstrDone),
        .Illegal     (Illegal),
        .Error       (Error)
    );

    assign obs = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, RegWrite, RegDst,
                  MemtoReg, ALUASrc, ALUBSrc, ALUControl, ExtendSign, InstrDone, Illegal, Error};

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    function automatic void push(input logic rdy, input logic z, input logic r,
                                 input logic [31:0] ins, input exp_t e);
        cyc_t c;
        c.rdy = rdy; c.zero = z; c.res0 = r; c.instr = ins; c.exp = e;
        q.push_back(c);
    endfunction

    // Reference model: expected per-cycle outputs of one instruction.
    // fw/mw = cycles MemReady stays low in fetch / data access; z,r = flags in the branch cycle.
    task automatic build(input logic [31:0] ins, input int fw, input int mw,
                         input logic z, input logic r);
        exp_t       e;
        int         kind;
        logic [5:0] op, fn;
        logic [4:0] rt;
        logic [3:0] alu;
        logic [1:0] bsrc;
        logic       asrc, ext, rdst, taken;
        op = ins[31:26]; fn = ins[5:0]; rt = ins[20:16];
        kind = K_ALU; alu = 4'd0; bsrc = 2'd1; asrc = 1'b0; ext = 1'b0; rdst = 1'b0; taken = 1'b0;
        if (ins == 32'd0) kind = K_NOP;
        else begin
            case (op)
                6'd0: begin
                    rdst = 1'b1; bsrc = 2'd0;
                    case (fn)
                        6'h20, 6'h21: alu = 4'd2;
                        6'h22: alu = 4'd6;
                        6'h24: alu = 4'd0;
                        6'h25: alu = 4'd1;
                        6'h27: alu = 4'd3;
                        6'h2A: alu = 4'd7;
                        6'h00: begin alu = 4'd10; asrc = 1'b1; bsrc = 2'd1; end
                        default: kind = K_ILL;
                    endcase
                end
                6'd8:  begin alu = 4'd2; ext = 1'b1; end
                6'd9:  alu = 4'd2;
                6'd12: alu = 4'd0;
                6'd13: alu = 4'd1;
                6'd35: kind = K_LW;
                6'd43: kind = K_SW;
                6'd4:  begin kind = K_BR; alu = 4'd6; bsrc = 2'd0; taken = z; end
                6'd5:  begin kind = K_BR; alu = 4'd6; bsrc = 2'd0; taken = !z; end
                6'd1:  begin kind = K_BR; alu = 4'd7; bsrc = 2'd2; taken = (rt == 5'd0) ? r : !r; end
                6'd7:  begin kind = K_BR; alu = 4'd11; bsrc = 2'd2; taken = r; end
                6'd2:  kind = K_J;
                6'd28: kind = K_MUL;
                default: kind = K_ILL;
            endcase
        end
        // fetch: garbage on the IR input until it is loaded
        for (int i = 0; i < fw; i++) begin
            e = '0; e.mem_read = 1'b1;
            push(1'b0, rb(), rb(), $urandom, e);
        end
        e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push(1'b1, rb(), rb(), $urandom, e);
        // decode
        e = '0;
        if (kind == K_NOP) e.instr_done = 1'b1;
        if (kind == K_ILL) begin e.illegal = 1'b1; e.instr_done = 1'b1; end
        push(rb(), rb(), rb(), ins, e);
        case (kind)
            K_ALU: begin
                e = '0; e.alu_ctrl = alu; e.alu_a_src = asrc; e.alu_b_src = bsrc; e.ext_sign = ext;
                push(rb(), rb(), rb(), ins, e);
                e = '0; e.reg_write = 1'b1; e.reg_dst = rdst; e.instr_done = 1'b1;
                push(rb(), rb(), rb(), ins, e);
            end
            K_LW, K_SW: begin
                e = '0; e.alu_ctrl = 4'd2; e.alu_b_src = 2'd1; e.ext_sign = 1'b1;
                push(rb(), rb(), rb(), ins, e);
                e = '0; e.iord = 1'b1; e.mem_read = (kind == K_LW); e.mem_write = (kind == K_SW);
                for (int i = 0; i < mw; i++) push(1'b0, rb(), rb(), ins, e);
                e.instr_done = (kind == K_SW);
                push(1'b1, rb(), rb(), ins, e);
                if (kind == K_LW) begin
                    e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
                    push(rb(), rb(), rb(), ins, e);
                end
            end
            K_BR: begin
                e = '0; e.alu_ctrl = alu; e.alu_b_src = bsrc; e.pc_source = 2'd1; e.instr_done = 1'b1;
                if (op == 6'd1 && rt > 5'd1) e.illegal = 1'b1;
                else e.pc_write = taken;
                push(rb(), z, r, ins, e);
            end
            K_J: begin
                e = '0; e.pc_write = 1'b1; e.pc_source = 2'd2; e.instr_done = 1'b1;
                push(rb(), rb(), rb(), ins, e);
            end
            K_MUL: begin
                e = '0; e.alu_ctrl = 4'd9;
                for (int i = 0; i < MUL_CYCLES; i++) push(rb(), rb(), rb(), ins, e);
                e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
                push(rb(), rb(), rb(), ins, e);
            end
            default: ;
        endcase
    endtask

    // Replay the queued trace; called just after a rising edge
    task automatic run_q(input string name);
        cyc_t c;
        for (int i = 0; i < q.size(); i++) begin
            c = q[i];
            MemReady = c.rdy; Zero = c.zero; ALUResult0 = c.res0; Instruction = c.instr;
            @(negedge Clk);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, c.exp);
            end
            @(posedge Clk); #1;
        end
        q.delete();
    endtask

    function automatic logic [31:0] rand_instr();
        int          ops[18] = '{0, 0, 0, 1, 1, 2, 4, 5, 7, 8, 9, 12, 13, 28, 35, 43, 3, 63};
        int          fns[10] = '{32, 33, 34, 36, 37, 39, 42, 0, 3, 24};
        logic [31:0] v;
        v = $urandom;
        v[31:26] = 6'(ops[$urandom_range(17)]);
        if (v[31:26] == 6'd0) v[5:0] = 6'(fns[$urandom_range(9)]);
        if (v[31:26] == 6'd1) v[20:16] = 5'($urandom_range(3));
        if ($urandom_range(15) == 0) v = 32'd0;
        return v;
    endfunction

    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemReady = rb(); Instruction = $urandom;
            @(negedge Clk);
            checks++;
            if (obs !== 21'd0) begin
                errors++;
                $display("FAIL reset_hold: got %h expected 000000", obs);
            end
            @(posedge Clk);
        end
        #1 Reset = 1'b1;
    endtask

    task automatic test_directed();
        build(32'h00221820, 0, 0, 1'b0, 1'b0); run_q("add");
        build(32'h8C220004, 0, 3, 1'b0, 1'b0); run_q("lw_wait3");
        build(32'hAC220008, 2, 1, 1'b0, 1'b0); run_q("sw_wait");
        build(32'h20228005, 1, 0, 1'b0, 1'b0); run_q("addi");
        build(32'h34220005, 0, 0, 1'b0, 1'b0); run_q("ori");
        build(32'h00021080, 0, 0, 1'b0, 1'b0); run_q("sll");
        build(32'h70221002, 0, 0, 1'b0, 1'b0); run_q("mul");
        build(32'h08000010, 0, 0, 1'b0, 1'b0); run_q("jump");
        build(32'h00000000, 0, 0, 1'b0, 1'b0); run_q("nop");
        build(32'h0022183F, 0, 0, 1'b0, 1'b0); run_q("bad_funct");
    endtask

    task automatic test_branches();
        build(32'h10220003, 0, 0, 1'b1, 1'b0); run_q("beq_taken");
        build(32'h10220003, 0, 0, 1'b0, 1'b1); run_q("beq_not_taken");
        build(32'h14220003, 0, 0, 1'b0, 1'b0); run_q("bne_taken");
        build(32'h1C200002, 0, 0, 1'b0, 1'b1); run_q("bgtz_taken");
        build(32'h04200002, 0, 0, 1'b1, 1'b1); run_q("bltz_taken");
        build(32'h04210002, 0, 0, 1'b0, 1'b1); run_q("bgez_not_taken");
        build(32'h04220002, 0, 0, 1'b1, 1'b1); run_q("regimm_bad_rt");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            build(rand_instr(), $urandom_range(3), $urandom_range(3), rb(), rb());
            run_q("random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) build(rand_instr(), 0, 0, rb(), rb());
        run_q("back_to_back");
    endtask

    task automatic test_timeout();
        exp_t e;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            e = '0; e.mem_read = 1'b1;
            push(1'b0, rb(), rb(), $urandom, e);
        end
        for (int i = 0; i < 4; i++) begin
            e = '0; e.error = 1'b1;
            push(rb(), rb(), rb(), $urandom, e);
        end
        run_q("fetch_timeout");
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (obs !== 21'd0) begin
            errors++;
            $display("FAIL timeout_reset_hold: got %h expected 000000", obs);
        end
        @(posedge Clk); #1 Reset = 1'b1;
        build(32'h00221820, 0, 0, 1'b0, 1'b0); run_q("after_timeout");
    endtask

    task automatic test_reset_mid_mem();
        exp_t e;
        build(32'hAC220008, 0, 2, 1'b0, 1'b0);
        void'(q.pop_back());
        run_q("sw_before_reset");
        Reset = 1'b0; MemReady = 1'b1;
        @(negedge Clk);
        checks++;
        if (obs !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid_mem: got %h expected 000000", obs);
        end
        @(posedge Clk); #1 Reset = 1'b1; MemReady = 1'b0;
        e = '0; e.mem_read = 1'b1;
        @(negedge Clk);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL fetch_after_reset: got %h expected %h", obs, e);
        end
        @(posedge Clk); #1;
        build(32'hFC000000, 0, 0, 1'b0, 1'b0); run_q("illegal_op63");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_branches();
        test_timeout();
        test_reset_mid_mem();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
